// File: rtl/mgt_01_fp_add_sub_ip.sv
// Purpose : IEEE-754 single-precision add/subtract (FADD.S / FSUB.S), round-to-nearest-even, FTZ inputs.
// Latency : 5 enabled cycles, capture in IDLE to result written in ROUND; one operation per 5 cycles.
// Backpr. : none; issue logic watches fu_state_o (FREE only in IDLE), clk_en_i=0 freezes everything.
// Ports   : clk_i, rst_i (async, active-high), clk_en_i; op_A_i/op_B_i/iw_funct7_i operands and opcode;
//           result_o plus underflow_o/overflow_o/invalid_op_o (registered, held until next ROUND);
//           fu_state_o (0=FREE, 1=BUSY).
module mgt_01_fp_add_sub_ip (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clk_en_i,
  input  logic [31:0] op_A_i,
  input  logic [31:0] op_B_i,
  input  logic [6:0]  iw_funct7_i,
  output logic [31:0] result_o,
  output logic        fu_state_o,
  output logic        underflow_o,
  output logic        overflow_o,
  output logic        invalid_op_o
);

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_e;

  localparam logic [6:0]  FSUB = 7'b0000100;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  state_e state_q, state_d;

  // captured operands
  logic [31:0] a_q, b_q;
  logic        sub_q;

  // ALIGN results: larger operand (l) and aligned smaller mantissa with G/R/S in [2:0]
  logic        spec_q, spec_inv_q;
  logic [31:0] spec_res_q;
  logic        sign_l_q, sign_s_q;
  logic [7:0]  exp_l_q;
  logic [23:0] mant_l_q;
  logic [26:0] mant_s_q;

  // ADD result: [27] carry, [26:3] mantissa, [2:0] G/R/S
  logic [27:0] sum_q;

  // NORM results: [26] hidden bit, [25:3] fraction, [2:0] G/R/S
  logic [26:0]       norm_q;
  logic signed [9:0] exp_n_q;
  logic              zero_q;

  // ---------------- ALIGN combinational ----------------
  logic        sign_a, sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] frac_a, frac_b;
  logic        nan_a, nan_b, inf_a, inf_b;
  logic [30:0] mag_a, mag_b;
  logic [23:0] mant_a, mant_b, mant_sm;
  logic        swap;
  logic [7:0]  exp_big, exp_sm, diff;
  logic [4:0]  sh;
  logic [49:0] shifted;
  logic        spec_d, spec_inv_d;
  logic [31:0] spec_res_d;

  always_comb begin
    sign_a  = a_q[31];
    sign_b  = b_q[31] ^ sub_q;
    exp_a   = a_q[30:23];
    exp_b   = b_q[30:23];
    frac_a  = a_q[22:0];
    frac_b  = b_q[22:0];
    nan_a   = (exp_a == 8'hFF) && (frac_a != 23'd0);
    nan_b   = (exp_b == 8'hFF) && (frac_b != 23'd0);
    inf_a   = (exp_a == 8'hFF) && (frac_a == 23'd0);
    inf_b   = (exp_b == 8'hFF) && (frac_b == 23'd0);
    // subnormals are flushed to zero before comparing and aligning
    mag_a   = (exp_a == 8'd0) ? 31'd0 : a_q[30:0];
    mag_b   = (exp_b == 8'd0) ? 31'd0 : b_q[30:0];
    mant_a  = (exp_a == 8'd0) ? 24'd0 : {1'b1, frac_a};
    mant_b  = (exp_b == 8'd0) ? 24'd0 : {1'b1, frac_b};
    swap    = mag_b > mag_a;
    exp_big = swap ? exp_b : exp_a;
    exp_sm  = swap ? exp_a : exp_b;
    mant_sm = swap ? mant_a : mant_b;
    diff    = exp_big - exp_sm;
    // beyond 26 positions the small operand only reaches the sticky bit
    sh      = (diff > 8'd26) ? 5'd26 : diff[4:0];
    shifted = {mant_sm, 26'd0} >> sh;

    spec_d     = nan_a | nan_b | inf_a | inf_b;
    spec_inv_d = 1'b0;
    spec_res_d = 32'd0;
    if (nan_a || nan_b) begin
      spec_res_d = QNAN;
      spec_inv_d = 1'b1;
    end else if (inf_a && inf_b && (sign_a != sign_b)) begin
      spec_res_d = QNAN;
      spec_inv_d = 1'b1;
    end else if (inf_a) begin
      spec_res_d = {sign_a, 8'hFF, 23'd0};
    end else if (inf_b) begin
      spec_res_d = {sign_b, 8'hFF, 23'd0};
    end
  end

  // ---------------- ADD combinational ----------------
  logic [27:0] sum_d;

  always_comb begin
    if (sign_l_q != sign_s_q)
      sum_d = {1'b0, mant_l_q, 3'b000} - {1'b0, mant_s_q};
    else
      sum_d = {1'b0, mant_l_q, 3'b000} + {1'b0, mant_s_q};
  end

  // ---------------- NORM combinational ----------------
  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    logic       found;
    n     = 5'd0;
    found = 1'b0;
    for (int i = 26; i >= 0; i--) begin
      if (!found) begin
        if (v[i]) found = 1'b1;
        else      n = n + 5'd1;
      end
    end
    return n;
  endfunction

  logic [4:0]        lz;
  logic [26:0]       norm_d;
  logic signed [9:0] exp_n_d;

  always_comb begin
    lz = lzc27(sum_q[26:0]);
    if (sum_q[27]) begin
      // the bit shifted out folds into sticky
      norm_d  = {sum_q[27:2], sum_q[1] | sum_q[0]};
      exp_n_d = $signed({2'b00, exp_l_q}) + 10'sd1;
    end else begin
      norm_d  = sum_q[26:0] << lz;
      exp_n_d = $signed({2'b00, exp_l_q}) - $signed({5'b00000, lz});
    end
  end

  // ---------------- ROUND combinational ----------------
  logic              rnd_up;
  logic [24:0]       mant_r;
  logic [22:0]       frac_r;
  logic signed [9:0] exp_r;
  logic [31:0]       res_d;
  logic              unf_d, ovf_d, inv_d;

  always_comb begin
    rnd_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    mant_r = {1'b0, norm_q[26:3]} + {24'd0, rnd_up};
    // rounding carry out of 1.111..1 leaves 10.000..0: fraction zero, exponent +1
    frac_r = mant_r[24] ? mant_r[23:1] : mant_r[22:0];
    exp_r  = exp_n_q + $signed({9'd0, mant_r[24]});

    res_d = {sign_l_q, exp_r[7:0], frac_r};
    unf_d = 1'b0;
    ovf_d = 1'b0;
    inv_d = 1'b0;
    if (spec_q) begin
      res_d = spec_res_q;
      inv_d = spec_inv_q;
    end else if (zero_q) begin
      // x - x gives +0; only two negative zeros added keep the minus sign
      res_d = {sign_l_q & sign_s_q, 31'd0};
    end else if (exp_r >= 10'sd255) begin
      res_d = {sign_l_q, 8'hFF, 23'd0};
      ovf_d = 1'b1;
    end else if (exp_n_q <= 10'sd0) begin
      res_d = {sign_l_q, 31'd0};
      unf_d = 1'b1;
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_d = IDLE;
    unique case (state_q)
      IDLE:    state_d = ALIGN;
      ALIGN:   state_d = ADD;
      ADD:     state_d = NORM;
      NORM:    state_d = ROUND;
      ROUND:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign fu_state_o = (state_q != IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      sub_q        <= 1'b0;
      spec_q       <= 1'b0;
      spec_inv_q   <= 1'b0;
      spec_res_q   <= 32'd0;
      sign_l_q     <= 1'b0;
      sign_s_q     <= 1'b0;
      exp_l_q      <= 8'd0;
      mant_l_q     <= 24'd0;
      mant_s_q     <= 27'd0;
      sum_q        <= 28'd0;
      norm_q       <= 27'd0;
      exp_n_q      <= 10'sd0;
      zero_q       <= 1'b0;
      result_o     <= 32'd0;
      underflow_o  <= 1'b0;
      overflow_o   <= 1'b0;
      invalid_op_o <= 1'b0;
    end else if (clk_en_i) begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          a_q   <= op_A_i;
          b_q   <= op_B_i;
          sub_q <= (iw_funct7_i == FSUB);
        end
        ALIGN: begin
          spec_q     <= spec_d;
          spec_inv_q <= spec_inv_d;
          spec_res_q <= spec_res_d;
          sign_l_q   <= swap ? sign_b : sign_a;
          sign_s_q   <= swap ? sign_a : sign_b;
          exp_l_q    <= exp_big;
          mant_l_q   <= swap ? mant_b : mant_a;
          mant_s_q   <= {shifted[49:26], shifted[25], shifted[24], |shifted[23:0]};
        end
        ADD: begin
          sum_q <= sum_d;
        end
        NORM: begin
          norm_q  <= norm_d;
          exp_n_q <= exp_n_d;
          zero_q  <= (sum_q == 28'd0);
        end
        ROUND: begin
          result_o     <= res_d;
          underflow_o  <= unf_d;
          overflow_o   <= ovf_d;
          invalid_op_o <= inv_d;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mgt_01_fp_add_sub_ip.sv
// Purpose : self-checking bench for mgt_01_fp_add_sub_ip (directed table, control sequences, random vs model).
// Latency : expects result and FREE 5 enabled cycles after capture.
// Backpr. : drives clk_en_i to stall mid-operation; rst_i pulsed mid-operation.
module tb_mgt_01_fp_add_sub_ip;

  localparam logic [6:0]  FADD = 7'b0000000;
  localparam logic [6:0]  FSUB = 7'b0000100;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic        clk, rst, clk_en;
  logic [31:0] op_a, op_b;
  logic [6:0]  funct7;
  logic [31:0] result;
  logic        fu_state, underflow, overflow, invalid_op;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [6:0]  f;
    logic [31:0] res;
    logic [2:0]  flg;  // {invalid, overflow, underflow}
  } vec_t;

  vec_t vecs[16];

  mgt_01_fp_add_sub_ip dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .clk_en_i     (clk_en),
    .op_A_i       (op_a),
    .op_B_i       (op_b),
    .iw_funct7_i  (funct7),
    .result_o     (result),
    .fu_state_o   (fu_state),
    .underflow_o  (underflow),
    .overflow_o   (overflow),
    .invalid_op_o (invalid_op)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Exact reference: operands become integers in units of 2^-149, are summed exactly,
  // then rounded to 24 significant bits with ties to even.
  function automatic logic [34:0] ref_model(input logic [31:0] a, input logic [31:0] b, input logic [6:0] f);
    logic         sa, sb, s, g, rest;
    logic [7:0]   ea, eb;
    logic [279:0] xa, xb, mag, tmp, one;
    logic [24:0]  m;
    int           p, e, sh;
    sa = a[31];
    sb = b[31] ^ (f == FSUB);
    ea = a[30:23];
    eb = b[30:23];
    if ((ea == 8'hFF && a[22:0] != 0) || (eb == 8'hFF && b[22:0] != 0)) return {3'b100, QNAN};
    if (ea == 8'hFF && eb == 8'hFF) return (sa != sb) ? {3'b100, QNAN} : {3'b000, sa, 8'hFF, 23'd0};
    if (ea == 8'hFF) return {3'b000, sa, 8'hFF, 23'd0};
    if (eb == 8'hFF) return {3'b000, sb, 8'hFF, 23'd0};
    xa = '0;
    xb = '0;
    if (ea != 0) begin xa[23:0] = {1'b1, a[22:0]}; xa = xa << (ea - 8'd1); end
    if (eb != 0) begin xb[23:0] = {1'b1, b[22:0]}; xb = xb << (eb - 8'd1); end
    if (sa == sb)      begin mag = xa + xb; s = sa; end
    else if (xa >= xb) begin mag = xa - xb; s = sa; end
    else               begin mag = xb - xa; s = sb; end
    if (mag == 0) return {3'b000, sa & sb, 31'd0};
    p = 0;
    for (int i = 0; i < 280; i++) if (mag[i]) p = i;
    e = p - 22;
    if (e <= 0) return {3'b001, s, 31'd0};
    sh  = p - 23;
    tmp = mag >> sh;
    m   = {1'b0, tmp[23:0]};
    if (sh > 0) begin
      one  = 1;
      g    = mag[sh-1];
      rest = (mag & ((one << (sh - 1)) - one)) != 0;
      if (g && (rest || m[0])) m = m + 25'd1;
    end
    if (m[24]) begin m = m >> 1; e = e + 1; end
    if (e >= 255) return {3'b010, s, 8'hFF, 23'd0};
    return {3'b000, s, 8'(e), m[22:0]};
  endfunction

  // Drive an operation while the unit is FREE and wait (bounded) for FREE again.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [6:0] f,
                        output logic [31:0] res, output logic [2:0] flg, output int lat);
    op_a   = a;
    op_b   = b;
    funct7 = f;
    lat    = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (fu_state && lat < 20);
    res = result;
    flg = {invalid_op, overflow, underflow};
  endtask

  initial begin
    logic [31:0] r, a, b, prev;
    logic [2:0]  fl;
    logic [6:0]  f;
    logic [34:0] m;
    int          lat, kind;
    logic        changed;

    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    clk_en  = 1'b1;
    op_a    = 32'd0;
    op_b    = 32'd0;
    funct7  = FADD;

    vecs[0]  = '{32'h41200000, 32'h40000000, FADD,       32'h41400000, 3'b000};
    vecs[1]  = '{32'h40600000, 32'h3FC00000, FADD,       32'h40A00000, 3'b000};
    vecs[2]  = '{32'h40600000, 32'h3FC00000, FSUB,       32'h40000000, 3'b000};
    vecs[3]  = '{32'h7FFFFFFF, 32'h3FC00000, FSUB,       32'h7FC00000, 3'b100};
    vecs[4]  = '{32'h7F800000, 32'h7F800000, FSUB,       32'h7FC00000, 3'b100};
    vecs[5]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, FADD,       32'h7F800000, 3'b010};
    vecs[6]  = '{32'h3F800000, 32'h3F800000, FSUB,       32'h00000000, 3'b000};
    vecs[7]  = '{32'h3F800000, 32'h33800000, FADD,       32'h3F800000, 3'b000};
    vecs[8]  = '{32'h3F800000, 32'h33800001, FADD,       32'h3F800001, 3'b000};
    vecs[9]  = '{32'h7F800000, 32'h3F800000, FSUB,       32'h7F800000, 3'b000};
    vecs[10] = '{32'h80000000, 32'h80000000, FADD,       32'h80000000, 3'b000};
    vecs[11] = '{32'h00800000, 32'h00800001, FSUB,       32'h80000000, 3'b001};
    vecs[12] = '{32'h41200000, 32'h40000000, 7'b0000101, 32'h41400000, 3'b000};
    vecs[13] = '{32'hFF800000, 32'hFF800000, FADD,       32'hFF800000, 3'b000};
    vecs[14] = '{32'h00400000, 32'h3F800000, FADD,       32'h3F800000, 3'b000};
    vecs[15] = '{32'h3F800000, 32'hBFC00000, FADD,       32'hBF000000, 3'b000};

    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 32'd0);
    check("reset_flags", {29'd0, invalid_op, overflow, underflow}, 32'd0);
    check("reset_fu_state", {31'd0, fu_state}, 32'd0);
    rst = 1'b0;

    // directed table
    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].f, r, fl, lat);
      check($sformatf("vec%0d_result", i), r, vecs[i].res);
      check($sformatf("vec%0d_flags", i), {29'd0, fl}, {29'd0, vecs[i].flg});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
    end

    // held inputs: back-to-back recomputation keeps result_o stable
    prev    = result;
    changed = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (result !== prev) changed = 1'b1;
    end
    check("hold_inputs_stable", {31'd0, changed}, 32'd0);

    // clk_en stall mid-operation: 2 enabled edges, 3 frozen, then 3 more to finish
    run_op(32'h40600000, 32'h3FC00000, FSUB, r, fl, lat);
    check("pre_stall_result", r, 32'h40000000);
    op_a   = 32'h41200000;
    op_b   = 32'h40000000;
    funct7 = FADD;
    repeat (2) begin @(posedge clk); #1; end
    clk_en  = 1'b0;
    changed = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
      if (result !== 32'h40000000 || fu_state !== 1'b1) changed = 1'b1;
    end
    check("stall_outputs_held", {31'd0, changed}, 32'd0);
    clk_en = 1'b1;
    lat = 0;
    do begin @(posedge clk); #1; lat++; end while (fu_state && lat < 20);
    check("stall_remaining_cycles", 32'(lat), 32'd3);
    check("stall_result", result, 32'h41400000);

    // reset mid-operation aborts it; outputs clear asynchronously
    run_op(32'h7F7FFFFF, 32'h7F7FFFFF, FADD, r, fl, lat);
    check("pre_reset_overflow", {29'd0, fl}, 32'd2);
    op_a   = 32'h40600000;
    op_b   = 32'h3FC00000;
    funct7 = FADD;
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    check("midop_reset_result", result, 32'd0);
    check("midop_reset_flags", {29'd0, invalid_op, overflow, underflow}, 32'd0);
    check("midop_reset_fu_state", {31'd0, fu_state}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    run_op(32'h40600000, 32'h3FC00000, FADD, r, fl, lat);
    check("post_reset_result", r, 32'h40A00000);
    check("post_reset_latency", 32'(lat), 32'd5);

    // random operations against the exact model
    for (int i = 0; i < 300; i++) begin
      a    = $urandom;
      b    = $urandom;
      kind = $urandom_range(0, 4);
      case (kind)
        1: begin  // near cancellation
          b[30:23] = a[30:23] - 8'($urandom_range(0, 1));
          b[22:10] = a[22:10];
        end
        2: begin  // tiny exponents: underflow region
          a[30:23] = 8'($urandom_range(0, 4));
          b[30:23] = 8'($urandom_range(0, 4));
        end
        3: begin  // huge exponents: overflow region
          a[30:23] = 8'($urandom_range(250, 254));
          b[30:23] = 8'($urandom_range(250, 254));
        end
        4: begin  // infinities and NaNs
          a[30:23] = 8'hFF;
          if ($urandom_range(0, 1) == 0) a[22:0] = 23'd0;
          if ($urandom_range(0, 1) == 0) begin
            b[30:23] = 8'hFF;
            if ($urandom_range(0, 2) != 0) b[22:0] = 23'd0;
          end
        end
        default: ;
      endcase
      case ($urandom_range(0, 4))
        0, 1:    f = FADD;
        2, 3:    f = FSUB;
        default: f = 7'($urandom);
      endcase
      m = ref_model(a, b, f);
      run_op(a, b, f, r, fl, lat);
      check($sformatf("rand%0d_result a=%h b=%h f=%h", i, a, b, f), r, m[31:0]);
      check($sformatf("rand%0d_flags", i), {29'd0, fl}, {29'd0, m[34:32]});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
